enemy_dir_picker: RTL

Consumer side of the 6-bit LFSR random stream. On request from the enemy control unit, it turns the free-running random word into a legal one-hot movement direction. It uses rejection sampling against a wall mask, applies a no-reversal rule, and falls back deterministically after a bounded number of tries. It sits between the lfsr instance and enemy_ctl_unit.

---
 rtl/enemy_dir_picker.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/enemy_dir_picker.sv
// ---------------------------------------------------------------------------
// enemy_dir_picker
// Turns the free-running LFSR word into a legal one-hot movement direction
// for the enemy control unit. It draws random candidates against the latched
// wall mask and never turns back unless the reverse is the only opening. If
// no candidate is accepted within MAX_TRIES draws, it picks a fixed fallback.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   rnd_data   random word from the lfsr; only bits [1:0] are used
//   req        request a new direction; sampled only while idle
//   allowed    open-path mask {right,left,down,up}; latched when req is taken
//   dir        chosen direction, one-hot {right,left,down,up}; held until next pulse
//   dir_valid  one-cycle pulse when dir is updated
//   stuck      pulses together with dir_valid when no path was open
//   busy       high while a draw is in progress
// ---------------------------------------------------------------------------
module enemy_dir_picker #(
    parameter int unsigned MAX_TRIES = 8,
    parameter int unsigned RND_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RND_W-1:0] rnd_data,
    input  logic             req,
    input  logic [3:0]       allowed,
    output logic [3:0]       dir,
    output logic             dir_valid,
    output logic             stuck,
    output logic             busy
);

    localparam int unsigned DIR_W = 4;
    localparam int unsigned TRY_W = 4;
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_t;

    state_t           r_state;
    logic [DIR_W-1:0] r_allow;
    logic [DIR_W-1:0] r_last_dir;
    logic [TRY_W-1:0] r_tries;
    logic [DIR_W-1:0] r_dir;
    logic             r_dir_valid;
    logic             r_stuck;
    logic             r_busy;

    logic [1:0]       w_idx;
    logic [DIR_W-1:0] w_idx_oh;
    logic [DIR_W-1:0] w_rev_of_last;
    logic             w_multi_open;
    logic [DIR_W-1:0] w_rev_mask;
    logic [DIR_W-1:0] w_elig;
    logic [DIR_W-1:0] w_lowest;
    logic             w_hit;
    logic             w_unused_rnd;

    // Candidate direction from the two low random bits.
    assign w_idx    = rnd_data[1:0];
    assign w_idx_oh = DIR_W'(4'b0001 << w_idx);

    // Upper random bits are intentionally ignored.
    assign w_unused_rnd = ^rnd_data[RND_W-1:2];

    // Reverse of a one-hot direction swaps up<->down and left<->right.
    assign w_rev_of_last = {r_last_dir[2], r_last_dir[3], r_last_dir[0], r_last_dir[1]};

    // More than one open path: clearing the lowest set bit leaves something.
    assign w_multi_open = (r_allow & DIR_W'(r_allow - 4'd1)) != '0;

    // Block turning back only when another way exists; dead ends may reverse.
    assign w_rev_mask = (r_last_dir != '0 && w_multi_open) ? w_rev_of_last : '0;
    assign w_elig     = r_allow & ~w_rev_mask;

    // Fallback is the lowest eligible bit: up > down > left > right.
    assign w_lowest = w_elig & DIR_W'(~w_elig + 4'd1);

    assign w_hit = (w_elig & w_idx_oh) != '0;

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_allow     <= '0;
            r_last_dir  <= '0;
            r_tries     <= '0;
            r_dir       <= '0;
            r_dir_valid <= 1'b0;
            r_stuck     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_dir_valid <= 1'b0;
            r_stuck     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_allow <= allowed;
                        r_tries <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (w_elig == '0) begin
                        // Walled in: report stuck, keep previous heading memory.
                        r_dir       <= '0;
                        r_stuck     <= 1'b1;
                        r_dir_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_hit) begin
                        r_dir       <= w_idx_oh;
                        r_last_dir  <= w_idx_oh;
                        r_dir_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (r_tries == TRY_LAST) begin
                        r_dir       <= w_lowest;
                        r_last_dir  <= w_lowest;
                        r_dir_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_tries <= r_tries + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dir       = r_dir;
    assign dir_valid = r_dir_valid;
    assign stuck     = r_stuck;
    assign busy      = r_busy;

endmodule
